// File: rtl/trivium_ks_sched.sv
`default_nettype none
// ============================================================================
//  Module   : trivium_ks_sched
//  Purpose  : Sequencer/arbiter for one bit-serial Trivium keystream core.
//             Loads key/IV into the core, runs the fixed warm-up, then shares
//             the keystream between two byte requesters. Each grant delivers
//             8 consecutive core bits packed LSB-first. The two requesters
//             are served round-robin.
//  Options  : TRIV_PREFETCH_EN - adds a one-byte keystream buffer that is
//             filled while no port is requesting. A request that finds the
//             buffer full is granted on the next cycle. Without the macro
//             there is no buffer and no prefetch state.
//  Ports    : clk_i          system clock, all logic on posedge
//             rst_ni         asynchronous active-low reset
//             start_i        1-cycle pulse: sample key/iv and (re)start keying
//             key_i, iv_i    80-bit key / nonce, sampled on start_i
//             busy_o         high in LOAD/WARM/GEN/DLVR (and PREF)
//             ready_o        high from warm-up completion until next start
//             core_load_o    1-cycle load strobe to the core
//             core_key_o     registered key to the core
//             core_iv_o      registered iv to the core
//             core_step_o    advance the core one step this cycle
//             core_ks_i      core keystream bit for the current (pre-step) state
//             req_i[1:0]     byte requests, held until the matching grant
//             gnt_o[1:0]     one-hot 1-cycle grant, ks_byte_o valid with it
//             ks_byte_o      packed keystream byte, first bit in bit 0
//  Revision : 1.0  initial release
// ============================================================================
module trivium_ks_sched #(
  parameter int WARM_STEPS = 1152,
  parameter int CNT_W      = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic        core_load_o,
  output logic [79:0] core_key_o,
  output logic [79:0] core_iv_o,
  output logic        core_step_o,
  input  logic        core_ks_i,
  input  logic [1:0]  req_i,
  output logic [1:0]  gnt_o,
  output logic [7:0]  ks_byte_o
);

  localparam logic [CNT_W-1:0] c_warm_last = CNT_W'(WARM_STEPS - 1);

`ifdef TRIV_PREFETCH_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WARM  = 3'd2,
    S_SERVE = 3'd3,
    S_GEN   = 3'd4,
    S_DLVR  = 3'd5,
    S_PREF  = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WARM  = 3'd2,
    S_SERVE = 3'd3,
    S_GEN   = 3'd4,
    S_DLVR  = 3'd5
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [6:0]         sreg_q, sreg_d;
  logic               sel_q, sel_d;
  logic               rr_q, rr_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               load_q, load_d;
  logic               step_q, step_d;
  logic [79:0]        key_q, key_d;
  logic [79:0]        iv_q, iv_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [7:0]         byte_q, byte_d;
`ifdef TRIV_PREFETCH_EN
  logic [7:0]         buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
`endif

  // Port chosen in SERVE: round-robin pointer on contention, else the
  // single requester (req_i[1] distinguishes 2'b10 from 2'b01).
  logic               w_pick;
  logic               w_any_req;
  // Bits arrive LSB first: shifting in at the top leaves the first bit in
  // bit 0 after the eighth sample, which is taken straight into the byte.
  logic [6:0]         w_shift;
  logic [7:0]         w_byte;

  assign w_any_req = (req_i != 2'b00);
  assign w_pick    = (req_i == 2'b11) ? rr_q : req_i[1];
  assign w_shift   = {core_ks_i, sreg_q[6:1]};
  assign w_byte    = {core_ks_i, sreg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    load_d  = 1'b0;
    step_d  = 1'b0;
    key_d   = key_q;
    iv_d    = iv_q;
    gnt_d   = 2'b00;
    byte_d  = byte_q;
`ifdef TRIV_PREFETCH_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif

    if (start_i) begin
      // Restart from any state: any byte in flight or buffered is dropped.
      state_d = S_LOAD;
      load_d  = 1'b1;
      key_d   = key_i;
      iv_d    = iv_i;
      busy_d  = 1'b1;
      ready_d = 1'b0;
      cnt_d   = '0;
      bit_d   = 3'd0;
`ifdef TRIV_PREFETCH_EN
      buf_full_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end

        S_LOAD: begin
          state_d = S_WARM;
          step_d  = 1'b1;
          cnt_d   = '0;
        end

        S_WARM: begin
          if (cnt_q == c_warm_last) begin
            state_d = S_SERVE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            step_d = 1'b1;
          end
        end

        S_SERVE: begin
`ifdef TRIV_PREFETCH_EN
          if (w_any_req && buf_full_q) begin
            state_d    = S_DLVR;
            sel_d      = w_pick;
            gnt_d      = w_pick ? 2'b10 : 2'b01;
            byte_d     = buf_q;
            buf_full_d = 1'b0;
            busy_d     = 1'b1;
          end else if (w_any_req) begin
            state_d = S_GEN;
            sel_d   = w_pick;
            step_d  = 1'b1;
            bit_d   = 3'd0;
            busy_d  = 1'b1;
          end else if (!buf_full_q) begin
            state_d = S_PREF;
            step_d  = 1'b1;
            bit_d   = 3'd0;
            busy_d  = 1'b1;
          end
`else
          if (w_any_req) begin
            state_d = S_GEN;
            sel_d   = w_pick;
            step_d  = 1'b1;
            bit_d   = 3'd0;
            busy_d  = 1'b1;
          end
`endif
        end

        S_GEN: begin
          sreg_d = w_shift;
          if (bit_q == 3'd7) begin
            state_d = S_DLVR;
            gnt_d   = sel_q ? 2'b10 : 2'b01;
            byte_d  = w_byte;
          end else begin
            bit_d  = bit_q + 3'd1;
            step_d = 1'b1;
          end
        end

        S_DLVR: begin
          state_d = S_SERVE;
          rr_d    = ~sel_q;
          busy_d  = 1'b0;
        end

`ifdef TRIV_PREFETCH_EN
        S_PREF: begin
          sreg_d = w_shift;
          if (bit_q == 3'd7) begin
            state_d    = S_SERVE;
            buf_d      = w_byte;
            buf_full_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            bit_d  = bit_q + 3'd1;
            step_d = 1'b1;
          end
        end
`endif

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sreg_q  <= 7'd0;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      key_q   <= 80'd0;
      iv_q    <= 80'd0;
      gnt_q   <= 2'b00;
      byte_q  <= 8'd0;
`ifdef TRIV_PREFETCH_EN
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      step_q  <= step_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      gnt_q   <= gnt_d;
      byte_q  <= byte_d;
`ifdef TRIV_PREFETCH_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign core_load_o = load_q;
  assign core_key_o  = key_q;
  assign core_iv_o   = iv_q;
  assign core_step_o = step_q;
  assign gnt_o       = gnt_q;
  assign ks_byte_o   = byte_q;

endmodule
`default_nettype wire

// File: tb/tb_trivium_ks_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trivium_ks_sched
//  Purpose  : Directed self-checking bench for trivium_ks_sched. A small core
//             model counts core_step pulses since the last core_load and
//             presents a fixed 32-bit pattern as keystream, so every byte is
//             known in advance: 8D, E1, 3C, 5A, then repeating.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trivium_ks_sched;

  localparam logic [79:0] KEY1 = 80'h9052aed66ce184be2329;
  localparam logic [79:0] IV1  = 80'h8cd13ffec22c8386202d;
  localparam logic [79:0] KEY2 = 80'h0123456789abcdef0246;
  localparam logic [79:0] IV2  = 80'hfedcba98765432101357;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic        busy;
  logic        ready;
  logic        core_load;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_step;
  logic        core_ks;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [7:0]  ks_byte;

  // Keystream pattern, consumed from bit 0 upward once warm-up is over.
  logic [31:0] pat   = 32'h5A3CE18D;
  logic [31:0] sc    = 32'd0;   // core steps since last load
  int          steps = 0;       // all core steps ever
  int          gnt_cnt = 0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trivium_ks_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .key_i       (key),
    .iv_i        (iv),
    .busy_o      (busy),
    .ready_o     (ready),
    .core_load_o (core_load),
    .core_key_o  (core_key),
    .core_iv_o   (core_iv),
    .core_step_o (core_step),
    .core_ks_i   (core_ks),
    .req_i       (req),
    .gnt_o       (gnt),
    .ks_byte_o   (ks_byte)
  );

  assign core_ks = pat[sc[4:0]];

  always @(posedge clk) begin
    if (core_load)      sc <= 32'd0;
    else if (core_step) sc <= sc + 32'd1;
    if (core_step)      steps <= steps + 1;
    if (gnt != 2'b00)   gnt_cnt <= gnt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [79:0] k, input logic [79:0] v);
    start = 1'b1;
    key   = k;
    iv    = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for a grant, bounded; returns number of negedges waited.
  task automatic wait_gnt(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 2'b00 && k < 40);
  endtask

  // Count consecutive cycles with core_step high, bounded.
  task automatic count_warm(output int n);
    n = 0;
    while (core_step && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int s0;
    int g0;

    rst_n = 1'b0;
    start = 1'b0;
    key   = 80'd0;
    iv    = 80'd0;
    req   = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",      busy,      1'b0);
    chk("rst_ready",     ready,     1'b0);
    chk("rst_core_load", core_load, 1'b0);
    chk("rst_core_step", core_step, 1'b0);
    chk("rst_gnt",       gnt,       2'b00);
    chk("rst_ks_byte",   ks_byte,   8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of warm-up
    pulse_start(KEY1, IV1);
    repeat (100) @(negedge clk);
    chk("midwarm_step", core_step, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     busy,      1'b0);
    chk("arst_step",     core_step, 1'b0);
    chk("arst_core_key", core_key,  80'd0);
    chk("arst_core_iv",  core_iv,   80'd0);
    s0 = steps;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_no_steps", steps, s0);
    chk("arst_idle_busy", busy, 1'b0);

    // Load and full warm-up
    pulse_start(KEY1, IV1);
    chk("load_strobe", core_load, 1'b1);
    chk("load_busy",   busy,      1'b1);
    chk("load_key",    core_key,  KEY1);
    chk("load_iv",     core_iv,   IV1);
    chk("load_nostep", core_step, 1'b0);
    @(negedge clk);
    chk("load_one_cycle", core_load, 1'b0);
    count_warm(n);
    chk("warm_len",   n,     1152);
    chk("warm_ready", ready, 1'b1);
    chk("warm_busy",  busy,  1'b0);
    chk("warm_sc",    sc,    32'd1152);

    // Single request on port 0, bits 1,0,1,1,0,0,0,1
    req = 2'b01;
    wait_gnt(k);
    chk("p0_lat",  k,       9);
    chk("p0_gnt",  gnt,     2'b01);
    chk("p0_byte", ks_byte, 8'h8D);
    chk("p0_sc",   sc,      32'd1160);

    // Single request on port 1 raised at the grant cycle
    req = 2'b10;
    wait_gnt(k);
    chk("p1_lat",  k,       10);
    chk("p1_gnt",  gnt,     2'b10);
    chk("p1_byte", ks_byte, 8'hE1);

    // Both held: round-robin continues from port 0
    req = 2'b11;
    wait_gnt(k);
    chk("rr1_lat",  k,       10);
    chk("rr1_gnt",  gnt,     2'b01);
    chk("rr1_byte", ks_byte, 8'h3C);
    wait_gnt(k);
    chk("rr2_lat",  k,       10);
    chk("rr2_gnt",  gnt,     2'b10);
    chk("rr2_byte", ks_byte, 8'h5A);
    wait_gnt(k);
    chk("rr3_lat",  k,       10);
    chk("rr3_gnt",  gnt,     2'b01);
    chk("rr3_byte", ks_byte, 8'h8D);

    // Restart during GEN step 4
    req = 2'b01;
    repeat (2) @(negedge clk);
    chk("gen_step", core_step, 1'b1);
    repeat (4) @(negedge clk);
    g0 = gnt_cnt;
    pulse_start(KEY2, IV2);
    chk("abort_load",  core_load, 1'b1);
    chk("abort_ready", ready,     1'b0);
    chk("abort_gnt",   gnt,       2'b00);
    chk("abort_key",   core_key,  KEY2);
    chk("abort_iv",    core_iv,   IV2);
    @(negedge clk);
    count_warm(n);
    chk("rewarm_len",   n,       1152);
    chk("rewarm_nognt", gnt_cnt, g0);
    chk("rewarm_ready", ready,   1'b1);
    wait_gnt(k);
    chk("fresh_lat",  k,       9);
    chk("fresh_gnt",  gnt,     2'b01);
    chk("fresh_byte", ks_byte, 8'h8D);
    req = 2'b00;
    @(negedge clk);
    chk("gnt_one_cycle", gnt, 2'b00);

`ifdef TRIV_PREFETCH_EN
    repeat (20) @(negedge clk);
    chk("pref_sc",   sc,   32'd1168);
    chk("pref_busy", busy, 1'b0);
    req = 2'b01;
    wait_gnt(k);
    chk("pref_lat",  k,       1);
    chk("pref_gnt",  gnt,     2'b01);
    chk("pref_byte", ks_byte, 8'hE1);
    wait_gnt(k);
    chk("pref2_slow", (k >= 9), 1'b1);
    chk("pref2_gnt",  gnt,      2'b01);
    chk("pref2_byte", ks_byte,  8'h3C);
    req = 2'b00;
`else
    s0 = steps;
    repeat (20) @(negedge clk);
    chk("serve_no_steps", steps, s0);
    chk("serve_busy",     busy,  1'b0);
    chk("serve_ready",    ready, 1'b1);
    chk("serve_sc",       sc,    32'd1160);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
